trace_arbiter: RTL and testbench

TRACE_ARBITER -- requirements
Module: trace_arbiter

---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_arbiter.sv | 144 ++++++++++++++
 tb/tb_trace_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace character constants and arbiter state encoding
package trace_pkg;

  localparam logic [7:0] CH_START = 8'h5E;
  localparam logic [7:0] CH_END   = 8'h23;
  localparam logic [7:0] CH_FILL  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2
  } trace_state_e;

endpackage

// File: rtl/trace_arbiter.sv
// rtl/trace_arbiter.sv - whole-frame arbiter sharing one trace checker between two requesters
module trace_arbiter
  import trace_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [7:0]    req0_char,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_char,
  output logic          req1_ready,
  output logic [7:0]    out_char,
  output logic          out_valid,
  output logic [1:0]    grant,
  output logic          frame_done,
  output logic          abort,
  output logic [CW-1:0] frame_cnt
);

  localparam int SW = $clog2(TIMEOUT + 1);

  trace_state_e  state_q, state_d;
  logic          rr_q, rr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    grant_q, grant_d;
  logic          frame_done_q, frame_done_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  logic       start0, start1, win1;
  logic       own_valid;
  logic [7:0] own_char;
  logic       rdy0, rdy1;

  assign start0    = req0_valid && (req0_char == CH_START);
  assign start1    = req1_valid && (req1_char == CH_START);
  assign win1      = start1 && (!start0 || rr_q);
  assign own_valid = grant_q[1] ? req1_valid : req0_valid;
  assign own_char  = grant_q[1] ? req1_char  : req0_char;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    stall_d      = stall_q;
    out_char_d   = out_char_q;
    out_valid_d  = 1'b0;
    grant_d      = grant_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Non-start characters are swallowed to resync; only the winning '^' is held off from nobody.
        rdy0 = req0_valid && (!start0 || !win1);
        rdy1 = req1_valid && (!start1 || win1);
        if (start0 || start1) begin
          out_char_d  = CH_START;
          out_valid_d = 1'b1;
          grant_d     = win1 ? 2'b10 : 2'b01;
          stall_d     = '0;
          state_d     = ST_PASS;
        end
      end
      ST_PASS: begin
        rdy0 = grant_q[0];
        rdy1 = grant_q[1];
        if (own_valid) begin
          out_char_d  = own_char;
          out_valid_d = 1'b1;
          stall_d     = '0;
          if (own_char == CH_END) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CW'(1);
            grant_d      = 2'b00;
            rr_d         = grant_q[0];
            state_d      = ST_IDLE;
          end
        end else begin
          stall_d = stall_q + SW'(1);
          if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        out_char_d  = CH_FILL;
        out_valid_d = 1'b1;
        abort_d     = 1'b1;
        grant_d     = 2'b00;
        rr_d        = grant_q[0];
        stall_d     = '0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      stall_q      <= '0;
      out_char_q   <= CH_FILL;
      out_valid_q  <= 1'b0;
      grant_q      <= 2'b00;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      stall_q      <= stall_d;
      out_char_q   <= out_char_d;
      out_valid_q  <= out_valid_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Readies are combinational, so they must be forced low while reset is held.
  assign req0_ready = reset && rdy0;
  assign req1_ready = reset && rdy1;
  assign out_char   = out_char_q;
  assign out_valid  = out_valid_q;
  assign grant      = grant_q;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// tb/tb_trace_arbiter.sv - directed vector bench for trace_arbiter
module tb_trace_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic [1:0] grant;
  logic       frame_done, abort;
  logic [1:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  trace_arbiter #(.TIMEOUT(16), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .out_char(out_char), .out_valid(out_valid), .grant(grant),
    .frame_done(frame_done), .abort(abort), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] c0;
    logic       v1;
    logic [7:0] c1;
    logic       rdy0;
    logic       rdy1;
    logic       ov;
    logic [7:0] oc;
    logic [1:0] gnt;
    logic       fd;
    logic       ab;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
    @(negedge clk);
    req0_valid = v0; req0_char = c0;
    req1_valid = v1; req1_char = c1;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string s;
    int    n;

    // garbage, tie, mid-frame '^', stall, hand-over to req1, sole contender, counter wrap
    vecs[0]  = '{1'b1, "x", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, "y", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, "z", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, "^", 1'b1, "^",   1'b1, 1'b0, 1'b1, "^",   2'b01, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, "A", 1'b1, "^",   1'b1, 1'b0, 1'b1, "A",   2'b01, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, "Q", 1'b1, "^",   1'b1, 1'b0, 1'b0, "A",   2'b01, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, "^", 1'b1, "^",   1'b1, 1'b0, 1'b1, "^",   2'b01, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, "#", 1'b1, "^",   1'b1, 1'b0, 1'b1, "#",   2'b00, 1'b1, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, "^", 1'b0, 1'b1, 1'b1, "^",   2'b10, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, "^", 1'b1, "B",   1'b0, 1'b1, 1'b1, "B",   2'b10, 1'b0, 1'b0, 2'd1};
    vecs[10] = '{1'b1, "^", 1'b1, "#",   1'b0, 1'b1, 1'b1, "#",   2'b00, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{1'b1, "^", 1'b1, "^",   1'b1, 1'b0, 1'b1, "^",   2'b01, 1'b0, 1'b0, 2'd2};
    vecs[12] = '{1'b1, "#", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "#",   2'b00, 1'b1, 1'b0, 2'd3};
    vecs[13] = '{1'b1, "^", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "^",   2'b01, 1'b0, 1'b0, 2'd3};
    vecs[14] = '{1'b1, "#", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "#",   2'b00, 1'b1, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "#", 2'b00, 1'b0, 1'b0, 2'd0};

    // reset state, with a requester presenting data so ready gating is exercised
    req0_valid = 1'b1; req0_char = "x";
    #2;
    chk("rst.ready0", req0_ready, 1'b0);
    chk("rst.out_char", out_char, 8'h00);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.grant", grant, 2'b00);
    chk("rst.flags", {frame_done, abort}, 2'b00);
    chk("rst.frame_cnt", frame_cnt, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v0, vecs[i].c0, vecs[i].v1, vecs[i].c1);
      chk($sformatf("v%0d.ready0", i), req0_ready, vecs[i].rdy0);
      chk($sformatf("v%0d.ready1", i), req1_ready, vecs[i].rdy1);
      edge_sample();
      chk($sformatf("v%0d.out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("v%0d.out_char", i), out_char, vecs[i].oc);
      chk($sformatf("v%0d.grant", i), grant, vecs[i].gnt);
      chk($sformatf("v%0d.frame_done", i), frame_done, vecs[i].fd);
      chk($sformatf("v%0d.abort", i), abort, vecs[i].ab);
      chk($sformatf("v%0d.frame_cnt", i), frame_cnt, vecs[i].cnt);
    end

    // full frame from req0, latency 1; fifth completed frame wraps counter to 1
    s = "^12@00003000: $5 <= 0000abcd#";
    n = s.len();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, s[i], 1'b0, 8'h00);
      chk($sformatf("f0[%0d].ready0", i), req0_ready, 1'b1);
      edge_sample();
      chk($sformatf("f0[%0d].out_char", i), out_char, s[i]);
      chk($sformatf("f0[%0d].out_valid", i), out_valid, 1'b1);
      chk($sformatf("f0[%0d].grant", i), grant, (i == n - 1) ? 2'b00 : 2'b01);
      chk($sformatf("f0[%0d].frame_done", i), frame_done, (i == n - 1) ? 1'b1 : 1'b0);
    end
    chk("f0.frame_cnt", frame_cnt, 2'd1);

    // req1 owns the frame then stalls into a timeout abort
    s = "^5@";
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, s[i]);
      chk($sformatf("st[%0d].ready1", i), req1_ready, 1'b1);
      edge_sample();
      chk($sformatf("st[%0d].out_char", i), out_char, s[i]);
      chk($sformatf("st[%0d].grant", i), grant, 2'b10);
    end
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      chk($sformatf("stall%0d.ready1", k), req1_ready, 1'b1);
      edge_sample();
      chk($sformatf("stall%0d.out_valid", k), out_valid, 1'b0);
      chk($sformatf("stall%0d.out_char", k), out_char, "@");
      chk($sformatf("stall%0d.abort", k), abort, 1'b0);
    end
    drive(1'b1, "^", 1'b1, "^");
    chk("abort.ready0", req0_ready, 1'b0);
    chk("abort.ready1", req1_ready, 1'b0);
    edge_sample();
    chk("abort.out_char", out_char, 8'h00);
    chk("abort.out_valid", out_valid, 1'b1);
    chk("abort.abort", abort, 1'b1);
    chk("abort.frame_done", frame_done, 1'b0);
    chk("abort.grant", grant, 2'b00);
    chk("abort.frame_cnt", frame_cnt, 2'd1);
    drive(1'b1, "^", 1'b1, "^");
    chk("post_abort.ready0", req0_ready, 1'b1);
    chk("post_abort.ready1", req1_ready, 1'b0);
    edge_sample();
    chk("post_abort.grant", grant, 2'b01);
    chk("post_abort.abort", abort, 1'b0);

    // 10 characters into a frame, then a two-cycle reset pulse
    s = "ABCDEFGHI";
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, s[i], 1'b0, 8'h00);
      edge_sample();
    end
    chk("pre_rst.out_char", out_char, "I");
    @(negedge clk);
    req0_char = "J";
    reset = 1'b0;
    #1;
    chk("mid_rst.ready0", req0_ready, 1'b0);
    chk("mid_rst.out_char", out_char, 8'h00);
    chk("mid_rst.out_valid", out_valid, 1'b0);
    chk("mid_rst.grant", grant, 2'b00);
    chk("mid_rst.frame_cnt", frame_cnt, 2'd0);
    for (int k = 0; k < 2; k++) begin
      edge_sample();
      chk($sformatf("mid_rst%0d.flags", k), {frame_done, abort}, 2'b00);
      chk($sformatf("mid_rst%0d.out_valid", k), out_valid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    s = "^ok#";
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, s[i]);
      chk($sformatf("rf[%0d].ready1", i), req1_ready, 1'b1);
      edge_sample();
      chk($sformatf("rf[%0d].out_char", i), out_char, s[i]);
      chk($sformatf("rf[%0d].grant", i), grant, (i == 3) ? 2'b00 : 2'b10);
      chk($sformatf("rf[%0d].flags", i), {frame_done, abort}, (i == 3) ? 2'b10 : 2'b00);
    end
    chk("rf.frame_cnt", frame_cnt, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
